// File: rtl/serial_full_adder.sv
// ---------------------------------------------------------------------------
// serial_full_adder
//
// Bit-serial adder: one full-adder cell with a registered carry. Operands are
// latched on an accepted start and consumed LSB-first, one bit per cycle, over
// W cycles. The result appears with a one-cycle done pulse and is held until
// the next accepted start.
//
// This block is the inverse of the full-subtractor cell: adding the subtrahend
// back to a difference recovers the minuend.
//
// Optional build macro: SERIAL_FULL_ADDER_SUB_EN
//   When defined, a 'sub' input is added. sub=1 computes a - b by loading ~b
//   and seeding the carry with 1. cout is then the no-borrow flag
//   (1 when a >= b unsigned). sub=0 is plain addition.
//   When undefined, the block only adds, which matches sub=0.
//
// Parameters:
//   W      operand/result width, 1..32
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset; aborts any operation in progress
//   start  request; sampled only in IDLE or in the done cycle
//   sub    (macro only) subtract select, latched with the operands
//   a, b   operands, latched when start is accepted
//   busy   high while the serial operation runs (W cycles)
//   done   one-cycle pulse when sum/cout become valid
//   sum    result, held until the next accepted start
//   cout   final carry (no-borrow when subtracting), held with sum
// ---------------------------------------------------------------------------
module serial_full_adder #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef SERIAL_FULL_ADDER_SUB_EN
    input  logic         sub,
`endif
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CNT_W = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Serial datapath registers
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     res;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    // Combinational helpers
    logic             accept;
    logic             last;
    logic             s;
    logic             carry_nxt;
    logic [W-1:0]     res_nxt;
    logic [W-1:0]     b_load;
    logic             carry_init;

    // -----------------------------------------------------------------------
    // Operand conditioning: subtraction is a + ~b + 1, so the inverted operand
    // and the seeded carry are chosen at load time and the cell never changes.
    // -----------------------------------------------------------------------
    always_comb begin
        b_load     = b;
        carry_init = 1'b0;
`ifdef SERIAL_FULL_ADDER_SUB_EN
        if (sub) begin
            b_load     = ~b;
            carry_init = 1'b1;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Full-adder cell and result shift. The new sum bit enters at the MSB so
    // that after W shifts the LSB-first stream lines up as a normal word.
    // -----------------------------------------------------------------------
    always_comb begin
        s         = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        res_nxt   = (res >> 1) | (W'(s) << (W - 1));
        last      = (cnt == CNT_W'(W - 1));
        // The done cycle accepts start exactly like IDLE for back-to-back ops.
        accept    = start && ((state == IDLE) || (state == DONE));
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last)   state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // -----------------------------------------------------------------------
    // Datapath. Start during RUN is ignored because accept is only true in
    // IDLE/DONE. sum/cout load only on the last RUN cycle (entry to DONE), so
    // partial results never become visible.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_load;
            res   <= '0;
            carry <= carry_init;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= res_nxt;
            carry <= carry_nxt;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                sum  <= res_nxt;
                cout <= carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_full_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_full_adder
//
// Directed, table-driven bench for serial_full_adder (W=4). A vector table of
// {a, b, sub, expected sum, expected cout} is applied in a loop, followed by
// hand-written sequences for hold, start-during-run, back-to-back start,
// reset abort and an exhaustive 256-pair sweep.
// Define SERIAL_FULL_ADDER_SUB_EN to also exercise the subtract vectors.
// ---------------------------------------------------------------------------
module tb_serial_full_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int nvec = 0;
    int nerr = 0;

    serial_full_adder #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_FULL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs[$];

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Wait for done; lat counts cycles from the call point, nb counts busy
    // cycles seen on the way. Bounded so a stuck DUT still reaches the summary.
    task automatic wait_done(output int lat, output int nb);
        lat = 0;
        nb  = 0;
        while (!done && lat < 30) begin
            if (busy) nb++;
            tick();
            lat++;
        end
    endtask

    // Issue one accepted start and wait for done. lat is measured in cycles
    // from the accepting edge, so a correct design gives lat == W+1.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic si, output int lat, output int nb);
        a     = ai;
        b     = bi;
        sub   = si;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~ai;     // operands may change freely after acceptance
        b     = ~bi;
        wait_done(lat, nb);
        lat = lat + 1;
    endtask

    initial begin
        int lat, nb, ndone;
        vec_t v;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;

        vecs.push_back('{a: 4'd15, b: 4'd1,  sub: 1'b0, s: 4'd0,  c: 1'b1});
        vecs.push_back('{a: 4'd0,  b: 4'd0,  sub: 1'b0, s: 4'd0,  c: 1'b0});
        vecs.push_back('{a: 4'd9,  b: 4'd9,  sub: 1'b0, s: 4'd2,  c: 1'b1});
        vecs.push_back('{a: 4'd15, b: 4'd15, sub: 1'b0, s: 4'd14, c: 1'b1});
        vecs.push_back('{a: 4'd8,  b: 4'd8,  sub: 1'b0, s: 4'd0,  c: 1'b1});
        vecs.push_back('{a: 4'd1,  b: 4'd2,  sub: 1'b0, s: 4'd3,  c: 1'b0});
        vecs.push_back('{a: 4'd10, b: 4'd5,  sub: 1'b0, s: 4'd15, c: 1'b0});
`ifdef SERIAL_FULL_ADDER_SUB_EN
        vecs.push_back('{a: 4'd5,  b: 4'd3,  sub: 1'b1, s: 4'd2,  c: 1'b1});
        vecs.push_back('{a: 4'd3,  b: 4'd5,  sub: 1'b1, s: 4'd14, c: 1'b0});
        vecs.push_back('{a: 4'd6,  b: 4'd6,  sub: 1'b1, s: 4'd0,  c: 1'b1});
        vecs.push_back('{a: 4'd0,  b: 4'd15, sub: 1'b1, s: 4'd1,  c: 1'b0});
        vecs.push_back('{a: 4'd12, b: 4'd4,  sub: 1'b0, s: 4'd0,  c: 1'b1});
`endif

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_sum",  int'(sum),  0);
        chk("reset_cout", int'(cout), 0);

        // First op: 5 + 3, latency and busy window, then hold for ten cycles
        run_op(4'd5, 4'd3, 1'b0, lat, nb);
        chk("op1_latency", lat, W + 1);
        chk("op1_busy_cycles", nb, W);
        chk("op1_sum",  int'(sum),  8);
        chk("op1_cout", int'(cout), 0);
        tick();
        chk("op1_done_pulse_width", int'(done), 0);
        a = 4'd15; b = 4'd15;
        repeat (10) tick();
        chk("op1_hold_sum",  int'(sum),  8);
        chk("op1_hold_cout", int'(cout), 0);
        chk("op1_hold_busy", int'(busy), 0);

        // Table vectors
        foreach (vecs[i]) begin
            v = vecs[i];
            run_op(v.a, v.b, v.sub, lat, nb);
            chk($sformatf("vec%0d_latency", i), lat, W + 1);
            chk($sformatf("vec%0d_sum", i),  int'(sum),  int'(v.s));
            chk($sformatf("vec%0d_cout", i), int'(cout), int'(v.c));
            tick();
        end
        sub = 1'b0;

        // Start during RUN is ignored; start in the done cycle is accepted
        a = 4'd5; b = 4'd3; start = 1'b1;
        tick();                        // accepted, first RUN cycle
        a = 4'd9; b = 4'd9;            // start still high during RUN
        tick();
        tick();
        start = 1'b0;
        wait_done(lat, nb);
        chk("ignore_done_seen", int'(done), 1);
        chk("ignore_sum",  int'(sum),  8);
        chk("ignore_cout", int'(cout), 0);
        a = 4'd9; b = 4'd9; start = 1'b1;   // in the done cycle
        tick();
        start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_done", int'(done), 0);
        chk("b2b_sum_held", int'(sum), 8);
        wait_done(lat, nb);
        chk("b2b_latency", lat + 1, W + 1);
        chk("b2b_sum",  int'(sum),  2);
        chk("b2b_cout", int'(cout), 1);
        tick();

        // Reset in the 2nd RUN cycle aborts with no done pulse
        a = 4'd7; b = 4'd7; start = 1'b1;
        tick();                        // RUN cycle 1
        start = 1'b0;
        tick();                        // RUN cycle 2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_sum",  int'(sum),  0);
        chk("abort_cout", int'(cout), 0);
        ndone = 0;
        repeat (8) begin
            if (done) ndone++;
            tick();
        end
        chk("abort_no_done", ndone, 0);

        // Exhaustive sweep of all operand pairs
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run_op(W'(ia), W'(ib), 1'b0, lat, nb);
                chk($sformatf("sweep_%0d_%0d_latency", ia, ib), lat, W + 1);
                chk($sformatf("sweep_%0d_%0d_result", ia, ib),
                    int'({cout, sum}), ia + ib);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/serial_full_adder.md
Name: serial_full_adder

Overview:
- Bit-serial adder: a single full-adder cell with a registered carry, fed operands LSB-first over W cycles.
- It is the inverse of the team's full-subtractor cell (difference/borrow). Adding the subtrahend back to a difference recovers the minuend.
- Sits beside the subtractor as a multi-cycle arithmetic unit with a start/done handshake.

Parameters:
- W, 4, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is idle or in its done cycle.
- a  input  W  operand A; latched when start is accepted.
- b  input  W  operand B; latched when start is accepted.
- busy  output  1  high while a serial operation is in progress.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  W  result; held until the next accepted start.
- cout  output  1  final carry; held with sum.

Behaviour:
- Reset: synchronous, active-high; applies on the clk edge where rst=1. Forces state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry=0.
- Reset takes priority over start and aborts any operation in progress. No done pulse is produced for an aborted operation.
- States:
  - IDLE: start=1 → load shift regs A←a, B←b, carry←0, cnt←0; go to RUN.
  - RUN: each cycle, s = A[0]^B[0]^carry; carry ← majority(A[0],B[0],carry).
    - A and B shift right by 1.
    - The result reg shifts right with s entering at bit W-1.
    - cnt increments. When cnt reaches W-1 (this is the last bit), go to DONE.
  - DONE: one cycle with done=1. sum = result reg and cout = carry, both stable from this cycle onward.
    - start=1 here is accepted exactly as in IDLE (back-to-back ops); go to RUN.
    - Otherwise go to IDLE.
- busy = 1 exactly in RUN.
- Latency: start accepted at edge k → busy high cycles k+1..k+W → done high in cycle k+W+1. Throughput is one result per W+1 cycles.
- start during RUN is ignored: no relatch, no restart, no error.
- a and b may change freely after acceptance; only the latched copies are used.
- sum/cout output registers update only on entry to DONE. They keep the old values throughout RUN (no partial results visible).
- Arithmetic: {cout,sum} = a + b, computed modulo 2^(W+1). Overflow appears only as cout=1.
- Counter width is clog2(W)+1. W=1 completes in one RUN cycle.

Optional Feature:
- Macro: SERIAL_FULL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with the operands.
  - sub=1 computes a - b: B is loaded as ~b and carry is initialised to 1.
  - cout is then the no-borrow flag: 1 when a ≥ b unsigned; borrow = ~cout, matching the subtractor cell's B output.
  - sum holds (a - b) mod 2^W.
  - sub=0 behaves exactly as addition.
- Undefined: no sub port; addition only. Behaviour is identical to sub=0.

Test Plan:
- W=4, reset then start with a=5, b=3 → busy for 4 cycles, done pulses on the 5th cycle after acceptance, sum=8, cout=0. Outputs still 8/0 ten cycles later.
- a=15, b=1 → sum=0, cout=1. Then a=0, b=0 → sum=0, cout=0.
- start with a=5, b=3, then start=1 with a=9, b=9 during RUN → ignored; result sum=8, cout=0. Next start in the done cycle with a=9, b=9 → accepted; busy the following cycle, result sum=2, cout=1.
- Start a=7, b=7; assert rst in the 2nd RUN cycle → next cycle busy=0, done=0, sum=0, cout=0. No done pulse follows.
- Exhaustive sweep: all 256 (a,b) pairs → {cout,sum} == a+b for each, with done appearing exactly W+1 cycles after start.
- With SERIAL_FULL_ADDER_SUB_EN defined:
  - a=5, b=3, sub=1 → sum=2, cout=1.
  - a=3, b=5, sub=1 → sum=14, cout=0 (borrow).
  - a=6, b=6, sub=1 → sum=0, cout=1.
